// File: rtl/hazard_detect_unit.sv
// Hazard detection and stall control for the five-stage pipeline, evaluated in ID.
// Covers load-use and branch-in-ID data hazards, and keeps saturating stall/flush counters.
module hazard_detect_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   input  logic                  id_uses_rt,
   input  logic                  id_branch,
   input  logic                  id_branch_taken,
   input  logic                  id_jump,
   input  logic                  idex_memRead,
   input  logic                  idex_regWrite,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic [REG_ADDR_W-1:0] idex_dst,
   input  logic                  exmem_memRead,
   input  logic [REG_ADDR_W-1:0] exmem_dst,
   output logic                  bubble_sel,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count,
   output logic                  state_dbg
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t state, state_next;

   logic match_idex_rt;
   logic match_idex_dst;
   logic match_exmem_dst;
   logic h_lu, h_bx, h_bl2, h_bl1;
   logic hazard_any;
   logic stall;

   // Register 0 is hardwired, so it can never be a producer worth waiting for.
   function automatic logic reg_match(input logic [REG_ADDR_W-1:0] x,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic [REG_ADDR_W-1:0] rt,
                                      input logic                  uses_rt);
      return (x != '0) && ((x == rs) || (uses_rt && (x == rt)));
   endfunction

   always_comb begin
      match_idex_rt   = reg_match(idex_rt,   ifid_rs, ifid_rt, id_uses_rt);
      match_idex_dst  = reg_match(idex_dst,  ifid_rs, ifid_rt, id_uses_rt);
      match_exmem_dst = reg_match(exmem_dst, ifid_rs, ifid_rt, id_uses_rt);
   end

   always_comb begin
      h_lu       = idex_memRead & match_idex_rt;
      h_bx       = id_branch & idex_regWrite & ~idex_memRead & match_idex_dst;
      h_bl2      = id_branch & idex_memRead & match_idex_rt;
      h_bl1      = id_branch & exmem_memRead & match_exmem_dst;
      hazard_any = h_lu | h_bx | h_bl2 | h_bl1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a load feeding a branch needs a second stall cycle.
   always_comb begin
      state_next = RUN;
      case (state)
         RUN:     state_next = h_bl2 ? HOLD : RUN;
         HOLD:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Output decode: stall wins over flush so a data-stalled taken branch flushes only once resolved.
   always_comb begin
      stall      = 1'b0;
      bubble_sel = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      case (state)
         RUN:     stall = hazard_any;
         HOLD:    stall = 1'b1;
         default: stall = hazard_any;
      endcase
      if (stall) begin
         bubble_sel = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b0;
      end else begin
         ifid_flush = id_jump | (id_branch & id_branch_taken);
      end
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (bubble_sel && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (ifid_flush && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: a 16-bit counter instance plus a 4-bit one
// sharing the same stimulus so counter saturation can be reached quickly.
module tb_hazard_detect_unit;

   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic [AW-1:0] ifid_rs, ifid_rt, idex_rt, idex_dst, exmem_dst;
   logic          id_uses_rt, id_branch, id_branch_taken, id_jump;
   logic          idex_memRead, idex_regWrite, exmem_memRead;

   logic          bubble_sel, pc_write, ifid_write, ifid_flush, state_dbg;
   logic [15:0]   stall_count, flush_count;
   logic          bubble_sel_s, pc_write_s, ifid_write_s, ifid_flush_s, state_dbg_s;
   logic [3:0]    stall_count_s, flush_count_s;

   int checks = 0;
   int errors = 0;

   hazard_detect_unit #(.REG_ADDR_W(AW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
      .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
      .idex_rt(idex_rt), .idex_dst(idex_dst),
      .exmem_memRead(exmem_memRead), .exmem_dst(exmem_dst),
      .bubble_sel(bubble_sel), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .stall_count(stall_count), .flush_count(flush_count),
      .state_dbg(state_dbg)
   );

   hazard_detect_unit #(.REG_ADDR_W(AW), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
      .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
      .idex_rt(idex_rt), .idex_dst(idex_dst),
      .exmem_memRead(exmem_memRead), .exmem_dst(exmem_dst),
      .bubble_sel(bubble_sel_s), .pc_write(pc_write_s), .ifid_write(ifid_write_s),
      .ifid_flush(ifid_flush_s), .stall_count(stall_count_s), .flush_count(flush_count_s),
      .state_dbg(state_dbg_s)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      ifid_rs = '0; ifid_rt = '0; id_uses_rt = 1'b0;
      id_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
      idex_memRead = 1'b0; idex_regWrite = 1'b0; idex_rt = '0; idex_dst = '0;
      exmem_memRead = 1'b0; exmem_dst = '0;
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      #1;
      // reset cycle: outputs follow RUN decode of idle inputs
      check("reset_bubble", 32'(bubble_sel), 32'd0);
      check("reset_pc_write", 32'(pc_write), 32'd1);
      step();
      step();
      check("reset_state", 32'(state_dbg), 32'd0);
      check("reset_stall_cnt", 32'(stall_count), 32'd0);
      check("reset_flush_cnt", 32'(flush_count), 32'd0);
      reset = 1'b0;

      // lw $8 ; add $9,$8,$2
      idex_memRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd2; id_uses_rt = 1'b1;
      #1;
      check("lu_bubble", 32'(bubble_sel), 32'd1);
      check("lu_pc_write", 32'(pc_write), 32'd0);
      check("lu_ifid_write", 32'(ifid_write), 32'd0);
      check("lu_flush", 32'(ifid_flush), 32'd0);
      step();
      idex_memRead = 1'b0; idex_rt = '0; exmem_memRead = 1'b1; exmem_dst = 5'd8;
      #1;
      check("lu_release_bubble", 32'(bubble_sel), 32'd0);
      check("lu_release_ifid_write", 32'(ifid_write), 32'd1);
      check("lu_state", 32'(state_dbg), 32'd0);
      check("lu_stall_cnt", 32'(stall_count), 32'd1);

      // lw $8 ; beq $8,$3 (taken)
      set_idle();
      idex_memRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3; id_uses_rt = 1'b1;
      id_branch = 1'b1; id_branch_taken = 1'b1;
      #1;
      check("bl_run_bubble", 32'(bubble_sel), 32'd1);
      check("bl_run_flush", 32'(ifid_flush), 32'd0);
      step();
      idex_memRead = 1'b0; idex_rt = '0; exmem_memRead = 1'b1; exmem_dst = 5'd8;
      #1;
      check("bl_hold_state", 32'(state_dbg), 32'd1);
      check("bl_hold_bubble", 32'(bubble_sel), 32'd1);
      check("bl_hold_flush", 32'(ifid_flush), 32'd0);
      step();
      exmem_memRead = 1'b0; exmem_dst = '0;
      #1;
      check("bl_resolve_state", 32'(state_dbg), 32'd0);
      check("bl_resolve_bubble", 32'(bubble_sel), 32'd0);
      check("bl_resolve_flush", 32'(ifid_flush), 32'd1);
      check("bl_resolve_pc_write", 32'(pc_write), 32'd1);
      check("bl_stall_cnt", 32'(stall_count), 32'd3);
      step();
      set_idle();
      #1;
      check("bl_flush_cnt", 32'(flush_count), 32'd1);
      check("bl_stall_cnt_hold", 32'(stall_count), 32'd3);

      // add $8 ; bne $4,$8 (not taken): rt match only counts when rt is read
      idex_regWrite = 1'b1; idex_dst = 5'd8; ifid_rs = 5'd4; ifid_rt = 5'd8;
      id_branch = 1'b1; id_uses_rt = 1'b0;
      #1;
      check("bx_no_rt_use", 32'(bubble_sel), 32'd0);
      id_uses_rt = 1'b1;
      #1;
      check("bx_bubble", 32'(bubble_sel), 32'd1);
      step();
      idex_regWrite = 1'b0; idex_dst = '0; exmem_dst = 5'd8;
      #1;
      check("bx_state", 32'(state_dbg), 32'd0);
      check("bx_release", 32'(bubble_sel), 32'd0);
      check("bx_not_taken_flush", 32'(ifid_flush), 32'd0);
      check("bx_stall_cnt", 32'(stall_count), 32'd4);

      // lw $0 ; add $9,$0,$2 then j
      set_idle();
      idex_memRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd2; id_uses_rt = 1'b1;
      #1;
      check("r0_bubble", 32'(bubble_sel), 32'd0);
      step();
      set_idle();
      id_jump = 1'b1;
      #1;
      check("j_flush", 32'(ifid_flush), 32'd1);
      check("j_pc_write", 32'(pc_write), 32'd1);
      check("j_bubble", 32'(bubble_sel), 32'd0);
      step();
      set_idle();
      #1;
      check("j_flush_cnt", 32'(flush_count), 32'd2);

      // branch with load in MEM only: one stall
      exmem_memRead = 1'b1; exmem_dst = 5'd3; ifid_rs = 5'd3; id_branch = 1'b1;
      #1;
      check("bl1_bubble", 32'(bubble_sel), 32'd1);
      step();
      set_idle();
      #1;
      check("bl1_state", 32'(state_dbg), 32'd0);
      check("bl1_release", 32'(bubble_sel), 32'd0);
      check("bl1_stall_cnt", 32'(stall_count), 32'd5);

      // reset while in HOLD
      idex_memRead = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; id_branch = 1'b1;
      step();
      set_idle();
      #1;
      check("rh_in_hold", 32'(state_dbg), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rh_state", 32'(state_dbg), 32'd0);
      check("rh_stall_cnt", 32'(stall_count), 32'd0);
      check("rh_flush_cnt", 32'(flush_count), 32'd0);
      check("rh_bubble", 32'(bubble_sel), 32'd0);
      step();
      check("rh_next_bubble", 32'(bubble_sel), 32'd0);

      // hold a load-use hazard for 20 cycles
      idex_memRead = 1'b1; idex_rt = 5'd12; ifid_rs = 5'd12;
      for (int i = 0; i < 20; i++) step();
      check("sat_small_stall_cnt", 32'(stall_count_s), 32'd15);
      check("sat_wide_stall_cnt", 32'(stall_count), 32'd20);
      check("sat_small_flush_cnt", 32'(flush_count_s), 32'd0);
      set_idle();
      step();
      check("sat_small_hold", 32'(stall_count_s), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Hazard detection and stall control for the five-stage MIPS pipeline; sits in ID and drives the select of the ID/EX control-bubble mux, the PC write enable and the IF/ID write/flush controls. Detects load-use hazards on ALU consumers and data hazards on branches resolved in ID. A small state machine holds the pipeline for the second cycle of a load-to-branch stall. Saturating counters expose stall and flush totals for debug.

## Interface
- REG_ADDR_W, 5, register-number width
- CNT_W, 16, width of stall/flush counters
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  synchronous, active-high
- ifid_rs, ifid_rt  input  REG_ADDR_W  source registers of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt (R-type, beq, bne, sw)
- id_branch  input  1  ID instruction is beq/bne
- id_branch_taken  input  1  ID comparator result, valid when id_branch
- id_jump  input  1  ID instruction is j
- idex_memRead, idex_regWrite  input  1  EX-stage controls (post-bubble-mux)
- idex_rt, idex_dst  input  REG_ADDR_W  EX load target / EX write register
- exmem_memRead  input  1  MEM-stage load flag
- exmem_dst  input  REG_ADDR_W  MEM-stage write register
- bubble_sel  output  1  1 = zero ID/EX control signals this cycle
- pc_write  output  1  1 = PC updates
- ifid_write  output  1  1 = IF/ID register loads
- ifid_flush  output  1  1 = IF/ID loads a nop
- stall_count  output  CNT_W  cycles with bubble_sel=1, saturating
- flush_count  output  CNT_W  cycles with ifid_flush=1, saturating

## Operation
- Match(x) := x != 0 && (x == ifid_rs || (id_uses_rt && x == ifid_rt)).
- H_lu (load-use): idex_memRead && Match(idex_rt).
- H_bx (branch on EX ALU result): id_branch && idex_regWrite && !idex_memRead && Match(idex_dst).
- H_bl2 (branch on load in EX): id_branch && idex_memRead && Match(idex_rt).
- H_bl1 (branch on load in MEM): id_branch && exmem_memRead && Match(exmem_dst).
- States: RUN, HOLD. Reset -> RUN.
- RUN: stall = H_lu | H_bx | H_bl2 | H_bl1. H_bl2 -> next HOLD; otherwise stay RUN.
- HOLD: stall = 1 unconditionally; next RUN.
- stall=1: bubble_sel=1, pc_write=0, ifid_write=0, ifid_flush=0.
- stall=0: bubble_sel=0, pc_write=1, ifid_write=1, ifid_flush = id_jump | (id_branch & id_branch_taken).
- Stall has priority over flush: a taken branch stalled for data does not flush until the cycle it resolves unstalled.
- Outputs bubble_sel, pc_write, ifid_write, ifid_flush are combinational from inputs and state (must act in the same cycle).
- stall_count += 1 when bubble_sel=1, flush_count += 1 when ifid_flush=1; both hold at 2^CNT_W-1.
- Register 0 never causes a hazard.

## Timing
- Reset values: state RUN, stall_count 0, flush_count 0; during reset cycle outputs follow RUN-state decode of inputs.
- Load-use: 1 bubble cycle; consumer re-evaluated next cycle with load in MEM (no hazard, forwarding covers it).
- Branch after ALU op: 1 stall. Branch after load: 2 stalls (RUN then HOLD), load then in WB.
- Branch with load in MEM only (e.g. one independent instruction between): 1 stall.
- reset asserted in HOLD: next state RUN, counters 0, no residual stall.
- Counters update on the same edge that ends the counted cycle; visible one cycle later.
- No combinational path from counters or state into hazard compare logic other than the HOLD bit.

## Test plan
- lw $8,0($1); add $9,$8,$2: cycle with add in ID, idex_memRead=1, idex_rt=8, ifid_rs=8 -> bubble_sel=1, pc_write=0, ifid_write=0 for exactly 1 cycle; stall_count=1.
- lw $8; beq $8,$3: idex_memRead=1, idex_rt=8, id_branch=1 -> 2 consecutive stall cycles (RUN->HOLD->RUN); third cycle with id_branch_taken=1 -> ifid_flush=1, flush_count=1.
- add $8,..; bne $4,$8: idex_regWrite=1, idex_dst=8, ifid_rt=8, id_uses_rt=1 -> 1 stall, no HOLD.
- lw $0,..; add $9,$0,$2 -> no stall; j with no hazard -> ifid_flush=1, pc_write=1, bubble_sel=0.
- Enter HOLD, assert reset one cycle -> state RUN, stall_count=0, flush_count=0, next cycle no stall with hazard-free inputs.
- Force CNT_W=4, hold H_lu for 20 cycles -> stall_count saturates at 15.
